// File: rtl/guess_checker_if.sv
`default_nettype none
// ============================================================================
//  Module      : guess_checker_if
//  Description : Bundle between the guess_checker and its environment.
//                The master side owns load/secret/guess inputs; the slave
//                side (the checker) owns the handshake ready, the digit
//                position and all scoring results.
//                  load            1  new-game pulse, captures secret_0..4
//                  secret_0..4     3  secret octal digits, positions 0..4
//                  guess_valid     1  guess_digit is presented
//                  guess_digit     3  player digit 0..7
//                  guess_ready     1  checker can take a digit
//                  digit_idx       3  position of next digit, 0..4
//                  result_valid    1  one-cycle pulse on hits/blows/tries update
//                  hits, blows     3  score of the last complete guess
//                  tries           4  complete guesses this game
//                  win, lose       1  game-over levels
//  Revision    : 1.0 - initial release
// ============================================================================
interface guess_checker_if;
    logic       load;
    logic [2:0] secret_0;
    logic [2:0] secret_1;
    logic [2:0] secret_2;
    logic [2:0] secret_3;
    logic [2:0] secret_4;
    logic       guess_valid;
    logic [2:0] guess_digit;
    logic       guess_ready;
    logic [2:0] digit_idx;
    logic       result_valid;
    logic [2:0] hits;
    logic [2:0] blows;
    logic [3:0] tries;
    logic       win;
    logic       lose;

    modport master (
        output load, secret_0, secret_1, secret_2, secret_3, secret_4,
        output guess_valid, guess_digit,
        input  guess_ready, digit_idx, result_valid, hits, blows, tries,
        input  win, lose
    );

    modport slave (
        input  load, secret_0, secret_1, secret_2, secret_3, secret_4,
        input  guess_valid, guess_digit,
        output guess_ready, digit_idx, result_valid, hits, blows, tries,
        output win, lose
    );
endinterface
`default_nettype wire

// File: rtl/guess_checker.sv
`default_nettype none
// ============================================================================
//  Module      : guess_checker
//  Description : Number-guessing game checker. Latches a 5-digit octal
//                secret on load, accepts a 5-digit guess one digit per
//                valid/ready handshake, then scores it with an 8-cycle pass
//                (one octal value per cycle) and reports hits and blows.
//                Tracks attempts and ends the game in WIN or LOSE.
//  Ports       : clk  - clock, all state on rising edge
//                rst  - asynchronous active-high reset
//                bus  - guess_checker_if.slave (load/secret/guess in,
//                       ready/index/result/win/lose out)
//  Parameters  : MAX_TRIES - complete guesses allowed before lose (1..15)
//  Revision    : 1.0 - initial release
// ============================================================================
module guess_checker #(
    parameter int MAX_TRIES = 8
) (
    input  wire logic      clk,
    input  wire logic      rst,
    guess_checker_if.slave bus
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_guess  = 3'd1;
    localparam logic [2:0] c_st_cmp    = 3'd2;
    localparam logic [2:0] c_st_report = 3'd3;
    localparam logic [2:0] c_st_win    = 3'd4;
    localparam logic [2:0] c_st_lose   = 3'd5;

    localparam logic [3:0] c_max_tries  = 4'(MAX_TRIES);
    localparam logic [2:0] c_last_idx   = 3'd4;
    localparam logic [2:0] c_last_value = 3'd7;
    localparam logic [2:0] c_all_hits   = 3'd5;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    logic [2:0] r_state;
    logic [2:0] w_state_next;

    logic [2:0] r_secret [5];
    logic [2:0] r_guess  [5];
    logic [2:0] r_digit_idx;
    logic [2:0] r_value;        // octal value being counted in the scoring pass
    logic [2:0] r_match;        // sum of per-value min(secret count, guess count)
    logic [2:0] r_hit_cnt;      // positional matches of the guess under scoring
    logic [2:0] r_hits;
    logic [2:0] r_blows;
    logic [3:0] r_tries;
    logic       r_result_valid;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic       w_accept;
    logic [3:0] w_tries_inc;
    logic [2:0] w_sec_cnt;      // occurrences of r_value in the secret
    logic [2:0] w_gss_cnt;      // occurrences of r_value in the guess
    logic [2:0] w_min_cnt;
    logic [2:0] w_hit_cnt;

    assign w_accept    = (r_state == c_st_guess) && bus.guess_valid;
    assign w_tries_inc = r_tries + 4'd1;

    // Per-value counts for the current scoring step, plus the positional
    // hit count. Hits only need to be captured once per guess; they are
    // recomputed every cycle but sampled only on the first scoring edge.
    always_comb begin
        w_sec_cnt = 3'd0;
        w_gss_cnt = 3'd0;
        w_hit_cnt = 3'd0;
        for (int i = 0; i < 5; i++) begin
            if (r_secret[i] == r_value) begin
                w_sec_cnt = w_sec_cnt + 3'd1;
            end
            if (r_guess[i] == r_value) begin
                w_gss_cnt = w_gss_cnt + 3'd1;
            end
            if (r_secret[i] == r_guess[i]) begin
                w_hit_cnt = w_hit_cnt + 3'd1;
            end
        end
        w_min_cnt = (w_sec_cnt < w_gss_cnt) ? w_sec_cnt : w_gss_cnt;
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic. load overrides every state, which also
    // aborts a scoring pass in progress.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        if (bus.load) begin
            w_state_next = c_st_guess;
        end else begin
            case (r_state)
                c_st_guess: begin
                    if (w_accept && (r_digit_idx == c_last_idx)) begin
                        w_state_next = c_st_cmp;
                    end
                end
                c_st_cmp: begin
                    if (r_value == c_last_value) begin
                        w_state_next = c_st_report;
                    end
                end
                c_st_report: begin
                    if (r_hit_cnt == c_all_hits) begin
                        w_state_next = c_st_win;
                    end else if (w_tries_inc == c_max_tries) begin
                        w_state_next = c_st_lose;
                    end else begin
                        w_state_next = c_st_guess;
                    end
                end
                c_st_idle, c_st_win, c_st_lose: begin
                    w_state_next = r_state;
                end
                default: begin
                    w_state_next = c_st_idle;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM: state-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        bus.guess_ready = 1'b0;
        bus.win         = 1'b0;
        bus.lose        = 1'b0;
        case (r_state)
            c_st_guess: bus.guess_ready = 1'b1;
            c_st_win:   bus.win         = 1'b1;
            c_st_lose:  bus.lose        = 1'b1;
            default:    ;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 5; i++) begin
                r_secret[i] <= 3'd0;
                r_guess[i]  <= 3'd0;
            end
            r_digit_idx    <= 3'd0;
            r_value        <= 3'd0;
            r_match        <= 3'd0;
            r_hit_cnt      <= 3'd0;
            r_hits         <= 3'd0;
            r_blows        <= 3'd0;
            r_tries        <= 4'd0;
            r_result_valid <= 1'b0;
        end else if (bus.load) begin
            // New game: a digit offered in the same cycle is dropped.
            r_secret[0]    <= bus.secret_0;
            r_secret[1]    <= bus.secret_1;
            r_secret[2]    <= bus.secret_2;
            r_secret[3]    <= bus.secret_3;
            r_secret[4]    <= bus.secret_4;
            for (int i = 0; i < 5; i++) begin
                r_guess[i] <= 3'd0;
            end
            r_digit_idx    <= 3'd0;
            r_value        <= 3'd0;
            r_match        <= 3'd0;
            r_hit_cnt      <= 3'd0;
            r_hits         <= 3'd0;
            r_blows        <= 3'd0;
            r_tries        <= 4'd0;
            r_result_valid <= 1'b0;
        end else begin
            r_result_valid <= 1'b0;
            case (r_state)
                c_st_guess: begin
                    if (w_accept) begin
                        for (int i = 0; i < 5; i++) begin
                            if (r_digit_idx == 3'(i)) begin
                                r_guess[i] <= bus.guess_digit;
                            end
                        end
                        if (r_digit_idx == c_last_idx) begin
                            r_digit_idx <= 3'd0;
                            r_value     <= 3'd0;
                            r_match     <= 3'd0;
                        end else begin
                            r_digit_idx <= r_digit_idx + 3'd1;
                        end
                    end
                end
                c_st_cmp: begin
                    // The total can never exceed 5 because each value's
                    // contribution is bounded by its count in the guess.
                    r_match <= r_match + w_min_cnt;
                    r_value <= r_value + 3'd1;
                    if (r_value == 3'd0) begin
                        r_hit_cnt <= w_hit_cnt;
                    end
                end
                c_st_report: begin
                    r_hits         <= r_hit_cnt;
                    r_blows        <= r_match - r_hit_cnt;
                    r_tries        <= w_tries_inc;
                    r_result_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.digit_idx    = r_digit_idx;
    assign bus.result_valid = r_result_valid;
    assign bus.hits         = r_hits;
    assign bus.blows        = r_blows;
    assign bus.tries        = r_tries;

endmodule
`default_nettype wire

// File: doc/guess_checker.md
Name: guess_checker

Overview:
- Consumer side of the octal random-digit generator in the number-guessing game.
- On `load`, latches the 5 secret octal digits the generator has produced.
- Then accepts player guesses one digit per handshake.
- After each complete 5-digit guess, runs a sequential 8-cycle scoring pass and reports hits (right digit, right place) and blows (right digit, wrong place); tracks attempts and flags win or lose.

Parameters:
- MAX_TRIES, 8, number of complete guesses allowed before lose; legal range 1..15.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- load  input  1  one-cycle pulse: capture secret_0..4 and start a new game; tie to the generator's done rising edge.
- secret_0 .. secret_4  input  3 each  secret digits, position 0..4.
- guess_valid  input  1  guess_digit is presented this cycle.
- guess_digit  input  3  player digit 0..7.
- guess_ready  output  1  high only in state GUESS; a digit is accepted when guess_valid & guess_ready at a rising edge.
- digit_idx  output  3  position of the next digit to be accepted, 0..4.
- result_valid  output  1  one-cycle pulse when hits/blows/tries are updated.
- hits  output  3  hits of last scored guess, 0..5.
- blows  output  3  blows of last scored guess, 0..5.
- tries  output  4  completed guesses this game.
- win  output  1  level, game won.
- lose  output  1  level, game lost.

Behaviour:
- Reset: state=IDLE; every output 0; secret and guess registers 0; internal counters 0.
- States: IDLE, GUESS, CMP, REPORT, WIN, LOSE.
- load (any state, highest priority after rst):
  - latch secret_0..4; clear guess regs, digit_idx, tries, hits, blows, win, lose; state=GUESS.
  - guess_valid in the same cycle is ignored.
- GUESS:
  - On an accepted digit, store it to guess[digit_idx] and increment digit_idx.
  - Acceptance of digit_idx=4 (edge E0): digit_idx→0, value counter v→0, match accumulator→0, state→CMP.
- CMP, edges E1..E8 process v=0..7, one value per edge:
  - match += min(count of v in secret, count of v in guess); counts are 0..5, accumulator 3 bits, never exceeds 5.
  - At E1 also compute hit count = number of positions i with secret[i]==guess[i]; store it internally.
  - At E8, state→REPORT.
- REPORT (edge E9):
  - hits ← hitcount; blows ← match − hitcount (never negative); tries ← tries+1; result_valid=1 for exactly the cycle after E9.
  - Next state: WIN if hitcount==5; else LOSE if tries+1==MAX_TRIES; else GUESS.
  - Latency from last digit accepted to result_valid high: 9 cycles.
- WIN/LOSE:
  - win or lose held high; guess_ready=0; outputs hold until load or rst.
- guess_valid outside GUESS: ignored, no state change, no stored data.
- hits, blows and tries hold their last value between results.
- rst mid-game (any state, including CMP): immediate return to the reset values; no result_valid.
- load during CMP or REPORT: abort scoring; no result_valid; tries not incremented.
- tries saturates logically at MAX_TRIES (the lose transition prevents further increments).

Test Plan:
- Exact match: load secret 1,2,3,4,5; guess 1,2,3,4,5 → result_valid 9 cycles after the 5th digit; hits=5, blows=0, tries=1, win=1, guess_ready=0.
- Permutation: same secret; guess 5,4,3,2,1 → hits=1, blows=4, tries=1, win=0, guess_ready=1 the cycle after result_valid.
- Duplicates: secret 0,0,1,1,2; guess 0,1,0,7,7 → hits=1, blows=2. Second guess 7,7,7,7,7 → hits=0, blows=0, tries=2.
- Lose: MAX_TRIES=8, secret 0,1,2,3,4; eight guesses of 7,7,7,7,7 → eight result_valid pulses, tries=8, lose=1 after the 8th; further guess_valid ignored (digit_idx stays 0).
- Ignored input: guess_valid pulsed during CMP and in IDLE → no change to digit_idx or result; load asserted with guess_valid during GUESS → digit_idx=0, tries=0, digit not stored.
- Asynchronous reset: assert rst during CMP cycle 4 → all outputs 0 immediately, state IDLE, no result_valid; after release, guess_ready=0 until load.
